// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing generator that streams 1-bit pixels from a 16-bit synchronous video RAM.
// Stage 0 is the counters, stage 1 sees the RAM data, stage 2 holds the registered outputs.
module vga_scanout #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int AWIDTH   = 15
) (
   input  logic              clk,
   input  logic              reset,
   output logic [AWIDTH-1:0] raddr,
   input  logic [15:0]       rdata,
   output logic              pixel,
   output logic              active,
   output logic              hs,
   output logic              vs,
   output logic              frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0]     hcount;
   logic [VW-1:0]     vcount;
   logic [AWIDTH-1:0] wcnt;
   logic [AWIDTH-1:0] wcur;
   logic [AWIDTH-1:0] raddr_q;
   logic              vis0, fetch0, hsa0, vsa0, fs0;
   logic              vis1, ld1, hsa1, vsa1, fs1;
   logic [15:0]       shreg;

   // The word counter restarts at (0,0), which is itself a fetch, so the first address of a frame is 0.
   always_comb begin
      fs0    = hcount == '0 && vcount == '0;
      vis0   = hcount < H_VIS && vcount < V_VIS;
      fetch0 = vis0 && hcount[3:0] == 4'd0;
      hsa0   = hcount >= HS_BEG && hcount < HS_END;
      vsa0   = vcount >= VS_BEG && vcount < VS_END;
      wcur   = fs0 ? '0 : wcnt;
      raddr  = fetch0 ? wcur : raddr_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hcount  <= '0;
         vcount  <= '0;
         wcnt    <= '0;
         raddr_q <= '0;
      end else begin
         hcount <= hcount == H_LAST ? '0 : hcount + HW'(1);
         if (hcount == H_LAST)
            vcount <= vcount == V_LAST ? '0 : vcount + VW'(1);
         if (fetch0) begin
            wcnt    <= wcur + AWIDTH'(1);
            raddr_q <= wcur;
         end
      end
   end

   // On a load cycle the leftmost pixel comes straight from rdata; shreg[14] is the next one after that.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vis1        <= 1'b0;
         ld1         <= 1'b0;
         hsa1        <= 1'b0;
         vsa1        <= 1'b0;
         fs1         <= 1'b0;
         shreg       <= '0;
         pixel       <= 1'b0;
         active      <= 1'b0;
         hs          <= 1'b1;
         vs          <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         vis1        <= vis0;
         ld1         <= fetch0;
         hsa1        <= hsa0;
         vsa1        <= vsa0;
         fs1         <= fs0;
         shreg       <= ld1 ? rdata : vis1 ? {shreg[14:0], 1'b0} : shreg;
         pixel       <= vis1 && (ld1 ? rdata[15] : shreg[14]);
         active      <= vis1;
         hs          <= !hsa1;
         vs          <= !vsa1;
         frame_start <= fs1;
      end
   end
endmodule
